// File: rtl/save_pkg.sv
// Shared constants and state encoding for the save engine.
package save_pkg;

    localparam int RD_LATENCY            = 4;
    localparam int DEF_BUFFER_ADDR_WIDTH = 11;
    localparam int DEF_BUFFER_DATA_WIDTH = 512;
    localparam int DEF_DDR_ADDR_WIDTH    = 64;
    localparam int DEF_LEN_WIDTH         = 12;
    localparam int DEF_FIFO_DEPTH        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/save_fifo.sv
// Synchronous FIFO holding buffer read returns until the DDR write master takes them.
module save_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 512,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/save_engine.sv
// Reads an instruction's beats out of the feature buffer and streams them to the
// DDR write master, with credit-limited issue so the return FIFO can never overflow.
module save_engine
    import save_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = DEF_BUFFER_ADDR_WIDTH,
    parameter int BUFFER_DATA_WIDTH = DEF_BUFFER_DATA_WIDTH,
    parameter int DDR_ADDR_WIDTH    = DEF_DDR_ADDR_WIDTH,
    parameter int LEN_WIDTH         = DEF_LEN_WIDTH,
    parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic [BUFFER_ADDR_WIDTH-1:0] inst_buf_addr,
    input  logic [DDR_ADDR_WIDTH-1:0]    inst_ddr_addr,
    input  logic [LEN_WIDTH-1:0]         inst_len,
    output logic                         save_read_addr_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0] save_read_addr,
    input  logic                         save_read_data_valid,
    input  logic [BUFFER_DATA_WIDTH-1:0] save_read_data,
    output logic                         wr_cmd_valid,
    input  logic                         wr_cmd_ready,
    output logic [DDR_ADDR_WIDTH-1:0]    wr_cmd_addr,
    output logic [LEN_WIDTH-1:0]         wr_cmd_len,
    output logic                         wr_data_valid,
    input  logic                         wr_data_ready,
    output logic [BUFFER_DATA_WIDTH-1:0] wr_data,
    output logic                         wr_data_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int IW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_depth_check
        $error("save_engine: FIFO_DEPTH must be at least RD_LATENCY+2");
    end

    state_e                       state_q, state_d;
    logic                         inst_ready_q, inst_ready_d;
    logic                         rd_valid_q, rd_valid_d;
    logic [BUFFER_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                         cmd_valid_q, cmd_valid_d;
    logic                         cmd_acc_q, cmd_acc_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic [BUFFER_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [DDR_ADDR_WIDTH-1:0]    ddr_addr_q, ddr_addr_d;
    logic [LEN_WIDTH-1:0]         len_q, len_d;
    logic [LEN_WIDTH-1:0]         issued_q, issued_d;
    logic [LEN_WIDTH-1:0]         sent_q, sent_d;
    logic [IW-1:0]                inflight_q, inflight_d;

    logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IW-1:0]                fifo_count;
    logic [BUFFER_DATA_WIDTH-1:0] fifo_rd_data;
    logic                         has_credit, issue, last_beat;

    save_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BUFFER_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (save_read_data),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Data is held back until the command has been accepted downstream.
    assign wr_data_valid = (state_q == ST_STREAM) && cmd_acc_q && !fifo_empty;
    assign wr_data       = wr_data_valid ? fifo_rd_data : '0;
    assign last_beat     = wr_data_valid && (sent_q == len_q - LEN_WIDTH'(1));
    assign wr_data_last  = last_beat;
    assign fifo_pop      = wr_data_valid && wr_data_ready;
    assign has_credit    = ((IW+1)'(fifo_count) + (IW+1)'(inflight_q)) < (IW+1)'(FIFO_DEPTH);

    always_comb begin
        state_d      = state_q;
        inst_ready_d = inst_ready_q;
        rd_valid_d   = 1'b0;
        rd_addr_d    = rd_addr_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_acc_d    = cmd_acc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        buf_addr_d   = buf_addr_q;
        ddr_addr_d   = ddr_addr_q;
        len_d        = len_q;
        issued_d     = issued_q;
        sent_d       = sent_q;
        inflight_d   = inflight_q;
        fifo_push    = 1'b0;
        issue        = 1'b0;

        if (save_read_data_valid) begin
            if (state_q == ST_STREAM && !fifo_full) begin
                fifo_push = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                inst_ready_d = 1'b1;
                if (inst_valid && inst_ready_q) begin
                    inst_ready_d = 1'b0;
                    buf_addr_d   = inst_buf_addr;
                    ddr_addr_d   = inst_ddr_addr;
                    len_d        = inst_len;
                    issued_d     = '0;
                    sent_d       = '0;
                    inflight_d   = '0;
                    cmd_acc_d    = 1'b0;
                    busy_d       = 1'b1;
                    if (inst_len != '0) begin
                        // First read goes out together with the STREAM entry.
                        state_d     = ST_STREAM;
                        cmd_valid_d = 1'b1;
                        rd_valid_d  = 1'b1;
                        rd_addr_d   = inst_buf_addr;
                        issued_d    = LEN_WIDTH'(1);
                        inflight_d  = IW'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_STREAM: begin
                if (cmd_valid_q && wr_cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cmd_acc_d   = 1'b1;
                end
                issue = (issued_q < len_q) && has_credit;
                if (issue) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = buf_addr_q + BUFFER_ADDR_WIDTH'(issued_q);
                    issued_d   = issued_q + LEN_WIDTH'(1);
                end
                inflight_d = inflight_q + IW'(issue) - IW'(save_read_data_valid);
                if (fifo_pop) begin
                    sent_d = sent_q + LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                cmd_acc_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inst_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_acc_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            buf_addr_q   <= '0;
            ddr_addr_q   <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            sent_q       <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            inst_ready_q <= inst_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_addr_q    <= rd_addr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_acc_q    <= cmd_acc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            buf_addr_q   <= buf_addr_d;
            ddr_addr_q   <= ddr_addr_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            sent_q       <= sent_d;
            inflight_q   <= inflight_d;
        end
    end

    assign inst_ready           = inst_ready_q;
    assign save_read_addr_valid = rd_valid_q;
    assign save_read_addr       = rd_addr_q;
    assign wr_cmd_valid         = cmd_valid_q;
    assign wr_cmd_addr          = ddr_addr_q;
    assign wr_cmd_len           = len_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign err                  = err_q;

endmodule

// File: tb/tb_save_engine.sv
// Scoreboard bench for save_engine: a 4-cycle buffer model feeds returns, the
// driver pushes expected reads/beats/commands, and a negedge monitor checks them.
module tb_save_engine;

    localparam int AW    = 11;
    localparam int DW    = 512;
    localparam int DDW   = 64;
    localparam int LW    = 12;
    localparam int DEPTH = 8;

    logic           clk;
    logic           rst;
    logic           inst_valid;
    logic           inst_ready;
    logic [AW-1:0]  inst_buf_addr;
    logic [DDW-1:0] inst_ddr_addr;
    logic [LW-1:0]  inst_len;
    logic           save_read_addr_valid;
    logic [AW-1:0]  save_read_addr;
    logic           save_read_data_valid;
    logic [DW-1:0]  save_read_data;
    logic           wr_cmd_valid;
    logic           wr_cmd_ready;
    logic [DDW-1:0] wr_cmd_addr;
    logic [LW-1:0]  wr_cmd_len;
    logic           wr_data_valid;
    logic           wr_data_ready;
    logic [DW-1:0]  wr_data;
    logic           wr_data_last;
    logic           busy;
    logic           done;
    logic           err;

    save_engine #(
        .BUFFER_ADDR_WIDTH (AW),
        .BUFFER_DATA_WIDTH (DW),
        .DDR_ADDR_WIDTH    (DDW),
        .LEN_WIDTH         (LW),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_valid           (inst_valid),
        .inst_ready           (inst_ready),
        .inst_buf_addr        (inst_buf_addr),
        .inst_ddr_addr        (inst_ddr_addr),
        .inst_len             (inst_len),
        .save_read_addr_valid (save_read_addr_valid),
        .save_read_addr       (save_read_addr),
        .save_read_data_valid (save_read_data_valid),
        .save_read_data       (save_read_data),
        .wr_cmd_valid         (wr_cmd_valid),
        .wr_cmd_ready         (wr_cmd_ready),
        .wr_cmd_addr          (wr_cmd_addr),
        .wr_cmd_len           (wr_cmd_len),
        .wr_data_valid        (wr_data_valid),
        .wr_data_ready        (wr_data_ready),
        .wr_data              (wr_data),
        .wr_data_last         (wr_data_last),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- buffer model: fixed 4-cycle read latency ----------------
    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int w = 0; w < 16; w++) begin
            d[w*32 +: 32] = {a, 5'(w), 16'hBEEF};
        end
        return d;
    endfunction

    logic [3:0]    pv;
    logic [AW-1:0] pa [4];
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[2:0], save_read_addr_valid};
            pa[0] <= save_read_addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pa[3] <= pa[2];
        end
    end
    assign save_read_data_valid = pv[3];
    assign save_read_data       = beat_data(pa[3]);

    // ---------------- scoreboard state ----------------
    logic [DW:0]        exp_q[$];
    int                 exp_beat_cyc_q[$];
    logic [AW-1:0]      exp_rd_q[$];
    int                 exp_rd_cyc_q[$];
    logic [DDW+LW-1:0]  exp_cmd_q[$];
    int                 exp_done_q[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int inst_rd  = 0;
    int inst_pop = 0;
    int done_cnt = 0;
    bit cmd_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flush_scoreboard();
        exp_q.delete();
        exp_beat_cyc_q.delete();
        exp_rd_q.delete();
        exp_rd_cyc_q.delete();
        exp_cmd_q.delete();
        exp_done_q.delete();
        inst_rd  = 0;
        inst_pop = 0;
        cmd_seen = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [AW-1:0]     ea;
        logic [DW:0]       eb;
        logic [DDW+LW-1:0] ecmd;
        int                ec;
        if (!rst) begin
            if (save_read_addr_valid) begin
                inst_rd++;
                chk("outstanding_le_depth", 64'(inst_rd - inst_pop <= DEPTH), 64'd1);
                if (exp_rd_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_read: got addr %0h expected no read (cycle %0d)", save_read_addr, cyc);
                end else begin
                    ea = exp_rd_q.pop_front();
                    ec = exp_rd_cyc_q.pop_front();
                    chk("read_addr", 64'(save_read_addr), 64'(ea));
                    if (ec >= 0) chk("read_cycle", 64'(cyc), 64'(ec));
                end
            end
            if (wr_data_valid) begin
                chk("data_after_cmd", 64'(cmd_seen), 64'd1);
                if (wr_data_ready) begin
                    inst_pop++;
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_beat: got last=%0b expected no beat (cycle %0d)", wr_data_last, cyc);
                    end else begin
                        eb = exp_q.pop_front();
                        ec = exp_beat_cyc_q.pop_front();
                        chk_cnt++;
                        if ({wr_data_last, wr_data} === eb) pass_cnt++;
                        else $display("FAIL beat: got %0h expected %0h (cycle %0d)", {wr_data_last, wr_data}, eb, cyc);
                        if (ec >= 0) chk("beat_cycle", 64'(cyc), 64'(ec));
                    end
                end
            end
            if (wr_cmd_valid && wr_cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_cmd: got addr %0h expected no command (cycle %0d)", wr_cmd_addr, cyc);
                end else begin
                    ecmd = exp_cmd_q.pop_front();
                    chk("cmd_addr", wr_cmd_addr, ecmd[DDW+LW-1:LW]);
                    chk("cmd_len", 64'(wr_cmd_len), 64'(ecmd[LW-1:0]));
                end
                cmd_seen = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    ec = exp_done_q.pop_front();
                    if (ec >= 0) chk("done_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_inst(input logic [AW-1:0] ba, input logic [DDW-1:0] da,
                             input logic [LW-1:0] len, input bit timed);
        logic [AW-1:0] a;
        bit hs;
        int t_hs;
        inst_rd  = 0;
        inst_pop = 0;
        cmd_seen = 1'b0;
        @(posedge clk); #1;
        inst_valid    = 1'b1;
        inst_buf_addr = ba;
        inst_ddr_addr = da;
        inst_len      = len;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            if (inst_ready) hs = 1'b1;
        end
        if (!hs) begin
            chk_cnt++;
            $display("FAIL inst_handshake_timeout: got no inst_ready expected handshake within 50 cycles");
        end
        t_hs = cyc;
        for (int i = 0; i < int'(len); i++) begin
            a = ba + AW'(i);
            exp_rd_q.push_back(a);
            exp_rd_cyc_q.push_back(timed ? t_hs + 1 + i : -1);
            exp_q.push_back({(i == int'(len) - 1), beat_data(a)});
            exp_beat_cyc_q.push_back(timed ? t_hs + 6 + i : -1);
        end
        if (len != '0) exp_cmd_q.push_back({da, len});
        exp_done_q.push_back(timed ? ((len == '0) ? t_hs + 2 : t_hs + 7 + int'(len)) : -1);
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int i = 0; i < 400 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) begin
            chk_cnt++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ctrl"}, 64'({inst_ready, save_read_addr_valid, wr_cmd_valid, wr_data_valid,
                                  wr_data_last, busy, done, err, save_read_addr, wr_cmd_len}), 64'd0);
        chk({name, "_cmd_addr"}, wr_cmd_addr, 64'd0);
        chk({name, "_wr_data"}, 64'(|wr_data), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst           = 1'b1;
        inst_valid    = 1'b0;
        inst_buf_addr = '0;
        inst_ddr_addr = '0;
        inst_len      = '0;
        wr_cmd_ready  = 1'b1;
        wr_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        chk("inst_ready_after_reset", 64'(inst_ready), 64'd1);

        // Basic 4-beat transfer with fixed latency checks.
        send_inst(11'h010, 64'h0000_0000_1000_0000, 12'd4, 1'b1);
        wait_done();
        chk("err_basic", 64'(err), 64'd0);

        // Zero-length no-op.
        send_inst(11'h055, 64'h0000_0000_2000_0000, 12'd0, 1'b1);
        @(negedge clk);
        chk("len0_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_inst_ready_low", 64'(inst_ready), 64'd0);
        @(negedge clk);
        chk("len0_inst_ready_back", 64'(inst_ready), 64'd1);

        // Buffer address wrap.
        send_inst(11'h7FE, 64'h0000_0000_3000_0040, 12'd4, 1'b1);
        wait_done();
        chk("err_wrap", 64'(err), 64'd0);

        // Data backpressure: issue must stop at FIFO_DEPTH.
        wr_data_ready = 1'b0;
        send_inst(11'h100, 64'h0000_0001_0000_0000, 12'd32, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_reads", 64'(inst_rd), 64'd8);
        @(posedge clk); #1 wr_data_ready = 1'b1;
        wait_done();
        chk("err_backpressure", 64'(err), 64'd0);

        // Command held off: no data before the command handshake, FIFO fills.
        wr_cmd_ready = 1'b0;
        send_inst(11'h200, 64'h0000_0002_0000_1000, 12'd12, 1'b0);
        repeat (9) @(negedge clk);
        chk("cmd_wait_reads", 64'(inst_rd), 64'd8);
        chk("cmd_wait_no_data", 64'(wr_data_valid), 64'd0);
        chk("cmd_wait_cmd_valid", 64'(wr_cmd_valid), 64'd1);
        @(posedge clk); #1 wr_cmd_ready = 1'b1;
        wait_done();
        chk("err_cmd_wait", 64'(err), 64'd0);

        // Reset in the middle of a 16-beat transfer, then a clean short one.
        send_inst(11'h300, 64'h0000_0003_0000_0000, 12'd16, 1'b0);
        for (int i = 0; i < 200 && inst_pop < 3; i++) @(negedge clk);
        chk("mid_beats_before_reset", 64'(inst_pop >= 3), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        flush_scoreboard();
        @(negedge clk);
        check_all_zero("mid_reset");
        send_inst(11'h020, 64'h0000_0004_0000_0000, 12'd2, 1'b1);
        wait_done();
        chk("err_after_reset", 64'(err), 64'd0);

        repeat (3) @(negedge clk);
        chk("beats_all_seen", 64'(exp_q.size()), 64'd0);
        chk("reads_all_seen", 64'(exp_rd_q.size()), 64'd0);
        chk("cmds_all_seen", 64'(exp_cmd_q.size()), 64'd0);
        chk("dones_all_seen", 64'(exp_done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
        $fatal(1, "simulation timeout");
    end

endmodule
